// File: rtl/div_share_ctrl_pkg.sv
// Shared types and constants for the time-shared iterative divider controller.
package div_share_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 16;

  localparam logic [DefaultWidth-1:0] Div0Quotient = '1;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Request/response handshake bundle between two requesters, a consumer and the shared divider.
interface div_share_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_dividend;
  logic [WIDTH-1:0] req0_divisor;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_dividend;
  logic [WIDTH-1:0] req1_divisor;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_quotient;
  logic [WIDTH-1:0] resp_remainder;
  logic             resp_div0;

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_div0
  );

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_quotient, resp_remainder, resp_div0
  );

endinterface

// File: rtl/div_share_step.sv
// One combinational restoring shift-subtract iteration of an unsigned divider.
module div_share_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, dvd_msb};
  assign diff    = shifted - {1'b0, divisor};

  // A carry out of the shift already exceeds any WIDTH-bit divisor; otherwise the sign decides.
  assign q_bit    = shifted[WIDTH] | ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one iterative unsigned divider between two requesters.
// Define DIV_SHARE_PERF_CNT_EN to build the saturating completed-operation counter.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  div_share_ctrl_if.slave bus,
  output logic [15:0]     op_count
);

  // Widen the all-ones pattern to whatever WIDTH is configured.
  localparam logic [WIDTH-1:0] Div0Q = {WIDTH{Div0Quotient[0]}};

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant;
  logic             any_valid;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign any_valid    = bus.req0_valid | bus.req1_valid;
  assign grant        = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign sel_dividend = grant ? bus.req1_dividend : bus.req0_dividend;
  assign sel_divisor  = grant ? bus.req1_divisor : bus.req0_divisor;

  div_share_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    id_d           = id_q;
    div0_d         = div0_q;
    dvd_d          = dvd_q;
    dvs_d          = dvs_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    cnt_d          = cnt_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          id_d           = grant;
          last_grant_d   = grant;
          dvs_d          = sel_divisor;
          cnt_d          = CNT_W'(WIDTH - 1);
          if (sel_divisor == '0) begin
            quo_d   = Div0Q;
            rem_d   = sel_dividend;
            div0_d  = 1'b1;
            state_d = StDone;
          end else begin
            dvd_d   = sel_dividend;
            quo_d   = '0;
            rem_d   = '0;
            div0_d  = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      div0_q       <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      div0_q       <= div0_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.resp_valid     = (state_q == StDone);
  assign bus.resp_id        = id_q;
  assign bus.resp_quotient  = quo_q;
  assign bus.resp_remainder = rem_q;
  assign bus.resp_div0      = div0_q;

`ifdef DIV_SHARE_PERF_CNT_EN
  logic        resp_hs;
  logic [15:0] op_cnt_q;

  assign resp_hs = bus.resp_valid & bus.resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
    end else if (resp_hs && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

endmodule
